// File: rtl/mem_block_copier_pkg.sv
// Shared types and constants for the word-granular memory block copier.
// FSM encoding, full-word byte enable, and legal read-latency range.
package mem_block_copier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;
    localparam int         RD_LAT_MIN     = 1;
    localparam int         RD_LAT_MAX     = 4;

    // Keeps an out-of-range READ_LATENCY from building a zero-width or oversized pipe.
    function automatic int rd_lat_clamp(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/mem_block_copier_rdlat.sv
// Capture strobe for read data: o_capture pulses exactly LAT cycles after i_accept.
// Pure delay line, no backpressure; cleared by synchronous reset.
module mem_block_copier_rdlat
    import mem_block_copier_pkg::*;
#(
    parameter int LAT = RD_LAT_MIN
) (
    input  logic clk,
    input  logic reset,
    input  logic i_accept,
    output logic o_capture
);

    logic [LAT-1:0] r_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_accept;
            for (int i = 1; i < LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_capture = r_pipe[LAT-1];

endmodule

// File: rtl/mem_block_copier.sv
// Avalon-MM forward block copier: read word, wait READ_LATENCY, write word; 3 cycles/word with no stalls.
// Requests hold stable under waitrequest. Optional running checksum output: MEM_BLOCK_COPIER_CHECKSUM_EN.
module mem_block_copier
    import mem_block_copier_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              read,
    output logic              write,
    output logic [31:0]       writedata,
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    input  logic [31:0]       readdata,
    input  logic              waitrequest
);

    localparam int LAT = rd_lat_clamp(READ_LATENCY);

    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_cnt;
    logic [31:0]       r_data;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_capture;

    assign w_rd_acc = (r_state == ST_RD_REQ) && !waitrequest;
    assign w_wr_acc = (r_state == ST_WR_REQ) && !waitrequest;

    mem_block_copier_rdlat #(.LAT(LAT)) u_rdlat (
        .clk       (clk),
        .reset     (reset),
        .i_accept  (w_rd_acc),
        .o_capture (w_capture)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_src   <= src_addr;
                    r_dst   <= dst_addr;
                    r_cnt   <= len;
                    r_state <= (len != '0) ? ST_RD_REQ : ST_DONE;
                end
                ST_RD_REQ: if (!waitrequest) r_state <= ST_RD_WAIT;
                ST_RD_WAIT: if (w_capture) begin
                    r_data  <= readdata;
                    r_state <= ST_WR_REQ;
                end
                // Pointers wrap silently at 2^ADDR_W.
                ST_WR_REQ: if (!waitrequest) begin
                    r_src   <= r_src + 1'b1;
                    r_dst   <= r_dst + 1'b1;
                    r_cnt   <= r_cnt - 1'b1;
                    r_state <= (r_cnt == LEN_W'(1)) ? ST_DONE : ST_RD_REQ;
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Gated by reset so a mid-copy reset drops the bus request in the same cycle.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        if (!reset) begin
            busy = (r_state != ST_IDLE);
            done = (r_state == ST_DONE);
            case (r_state)
                ST_RD_REQ: begin
                    read    = 1'b1;
                    address = r_src;
                end
                ST_WR_REQ: begin
                    write     = 1'b1;
                    address   = r_dst;
                    writedata = r_data;
                end
                default: ;
            endcase
        end
    end

    assign chipselect = read | write;
    assign byteenable = BYTEENABLE_ALL;

`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_sum <= '0;
        end else if (w_wr_acc) begin
            r_sum <= r_sum + r_data;
        end
    end

    assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier with a 1-cycle-latency Avalon slave memory model.
module tb_mem_block_copier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    mem_block_copier dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .address     (address),
        .byteenable  (byteenable),
        .chipselect  (chipselect),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    always #5 clk = ~clk;

    // Slave memory: preload port for the bench, bus writes from the DUT, fixed 1-cycle read data.
    logic [31:0] mem [0:1023];
    logic        pl_en   = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_dat  = '0;
    bit          stall_en = 1'b0;

    initial waitrequest = 1'b0;
    initial readdata    = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_dat;
        else if (write && !waitrequest) mem[address] <= writedata;
        if (read && !waitrequest) readdata <= mem[address];
        waitrequest <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Bus monitor: activity counters, acceptance logs, protocol/stability violations.
    int         busy_cnt  = 0;
    int         done_cnt  = 0;
    int         done_at   = 0;
    int         proto_err = 0;
    logic [9:0] rd_log[$];
    logic [9:0] wr_log[$];
    bit         p_stall = 1'b0;
    logic [43:0] p_req  = '0;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_at = busy_cnt;
        end
        if (read && write) proto_err++;
        if (chipselect !== (read | write)) proto_err++;
        if (byteenable !== 4'hF) proto_err++;
        if (p_stall && !reset && ({read, write, address, writedata} !== p_req)) proto_err++;
        p_stall = (read | write) && waitrequest;
        p_req   = {read, write, address, writedata};
        if (read && !waitrequest) rd_log.push_back(address);
        if (write && !waitrequest) wr_log.push_back(address);
    end

    task automatic poke(input logic [9:0] a, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_dat = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic start_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout done=%b required 1", name, done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, chipselect, read, write, address, writedata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got b%b d%b cs%b r%b w%b a%h wd%h required all 0",
                     busy, done, chipselect, read, write, address, writedata);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic_copy();
        int b0, d0;
        logic [31:0] exp_w [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int i = 0; i < 4; i++) poke(10'h010 + 10'(i), exp_w[i]);
        b0 = busy_cnt; d0 = done_cnt;
        start_copy(10'h010, 10'h200, 11'd4);
        wait_done("basic");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[10'h200 + 10'(i)] !== exp_w[i]) begin
                errors++;
                $display("FAIL basic_word%0d got %h required %h", i, mem[10'h200 + 10'(i)], exp_w[i]);
            end
        end
        checks++;
        if (busy_cnt - b0 != 13) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d required 13", busy_cnt - b0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL basic_done_pulses got %0d required 1", done_cnt - d0);
        end
        checks++;
        if (done_at - b0 != 13) begin
            errors++;
            $display("FAIL basic_done_position got %0d required 13", done_at - b0);
        end
    endtask

    task automatic test_zero_len();
        int b0, d0, r0, w0;
        b0 = busy_cnt; d0 = done_cnt; r0 = rd_log.size(); w0 = wr_log.size();
        start_copy(10'h020, 10'h220, 11'd0);
        wait_done("zero_len");
        checks++;
        if (busy_cnt - b0 != 1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL zero_len_pulse busy=%0d done=%0d required 1 1", busy_cnt - b0, done_cnt - d0);
        end
        checks++;
        if (rd_log.size() != r0 || wr_log.size() != w0) begin
            errors++;
            $display("FAIL zero_len_bus reads=%0d writes=%0d required 0 0",
                     rd_log.size() - r0, wr_log.size() - w0);
        end
    endtask

    task automatic test_stalls();
        int p0, w0;
        for (int i = 0; i < 8; i++) poke(10'h100 + 10'(i), 32'hA0000000 + i);
        p0 = proto_err; w0 = wr_log.size();
        stall_en = 1'b1;
        start_copy(10'h100, 10'h180, 11'd8);
        wait_done("stalls");
        stall_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[10'h180 + 10'(i)] !== 32'hA0000000 + i) begin
                errors++;
                $display("FAIL stall_word%0d got %h required %h", i, mem[10'h180 + 10'(i)], 32'hA0000000 + i);
            end
        end
        checks++;
        if (wr_log.size() - w0 != 8 || proto_err != p0) begin
            errors++;
            $display("FAIL stall_protocol writes=%0d violations=%0d required 8 0",
                     wr_log.size() - w0, proto_err - p0);
        end
    endtask

    task automatic test_wrap();
        int r0, w0;
        logic [9:0]  exp_rd [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        logic [31:0] exp_m  [4] = '{32'hAAAA0001, 32'hBBBB0002, 32'hAAAA0001, 32'hBBBB0002};
        poke(10'h3FE, 32'hAAAA0001);
        poke(10'h3FF, 32'hBBBB0002);
        poke(10'h000, 32'hCCCC0003);
        poke(10'h001, 32'hDDDD0004);
        r0 = rd_log.size(); w0 = wr_log.size();
        start_copy(10'h3FE, 10'h000, 11'd4);
        wait_done("wrap");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_log[r0 + i] !== exp_rd[i] || wr_log[w0 + i] !== 10'(i)) begin
                errors++;
                $display("FAIL wrap_addr%0d rd=%h wr=%h required rd=%h wr=%h",
                         i, rd_log[r0 + i], wr_log[w0 + i], exp_rd[i], 10'(i));
            end
            checks++;
            if (mem[10'(i)] !== exp_m[i]) begin
                errors++;
                $display("FAIL wrap_data%0d got %h required %h", i, mem[10'(i)], exp_m[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int w0, d0, r1, k;
        for (int i = 0; i < 6; i++) poke(10'h040 + 10'(i), 32'h50000000 + i);
        poke(10'h0C2, 32'hDEADBEEF);
        w0 = wr_log.size(); d0 = done_cnt; k = 0;
        start_copy(10'h040, 10'h0C0, 11'd6);
        while (wr_log.size() < w0 + 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, chipselect, read, write, address, writedata} !== '0) begin
            errors++;
            $display("FAIL abort_outputs got b%b d%b cs%b r%b w%b a%h wd%h required all 0",
                     busy, done, chipselect, read, write, address, writedata);
        end
        reset = 1'b0;
        r1 = rd_log.size();
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt != d0 || rd_log.size() != r1 || wr_log.size() != w0 + 2) begin
            errors++;
            $display("FAIL abort_quiet busy=%b done=%0d reads=%0d writes=%0d required 0 0 0 2",
                     busy, done_cnt - d0, rd_log.size() - r1, wr_log.size() - w0);
        end
        checks++;
        if (mem[10'h0C1] !== 32'h50000001 || mem[10'h0C2] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL abort_mem got %h %h required 50000001 deadbeef", mem[10'h0C1], mem[10'h0C2]);
        end
        poke(10'h050, 32'h12345678);
        poke(10'h051, 32'h9ABCDEF0);
        start_copy(10'h050, 10'h0D0, 11'd2);
        wait_done("after_abort");
        checks++;
        if (mem[10'h0D0] !== 32'h12345678 || mem[10'h0D1] !== 32'h9ABCDEF0) begin
            errors++;
            $display("FAIL after_abort_copy got %h %h required 12345678 9abcdef0", mem[10'h0D0], mem[10'h0D1]);
        end
    endtask

`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    task automatic test_checksum();
        poke(10'h300, 32'hFFFFFFFF);
        poke(10'h301, 32'h00000002);
        start_copy(10'h300, 10'h310, 11'd2);
        wait_done("checksum");
        checks++;
        if (checksum !== 32'h00000001) begin
            errors++;
            $display("FAIL checksum_value got %h required 00000001", checksum);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (checksum !== 32'h00000001) begin
            errors++;
            $display("FAIL checksum_hold got %h required 00000001", checksum);
        end
    endtask
`endif

    task automatic test_protocol();
        checks++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL protocol_violations got %0d required 0", proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_stalls();
        test_wrap();
        test_reset_abort();
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
        test_checksum();
`endif
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_block_copier.md
MEM_BLOCK_COPIER -- requirements
Module: mem_block_copier

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 10, meaning the width of the word address on the Avalon-MM master port.
REQ-002 The block SHALL take parameter LEN_W, default 11, meaning the width of the word-count input.
REQ-003 The block SHALL take parameter READ_LATENCY, default 1, meaning the fixed slave read latency in cycles; the legal range is 1..4.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a copy.
REQ-007 The block SHALL have ports src_addr and dst_addr, input, ADDR_W bits each, the word addresses of the first source and first destination words.
REQ-008 The block SHALL have port len, input, LEN_W bits, the number of words to copy.
REQ-009 The block SHALL have port busy, output, 1 bit, meaning a copy is in progress.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-011 The block SHALL have ports address (ADDR_W), byteenable (4), chipselect (1), read (1), write (1) and writedata (32), all outputs, forming the Avalon-MM master request.
REQ-012 The block SHALL have ports readdata (32) and waitrequest (1), both inputs, forming the Avalon-MM master response.

Function
REQ-013 The block SHALL use the states IDLE, RD_REQ, RD_WAIT, WR_REQ and DONE.
REQ-014 In IDLE, when start=1, the block SHALL latch src_addr, dst_addr and len, and go to RD_REQ if len≠0, otherwise to DONE.
REQ-015 A start pulse SHALL be ignored in every state other than IDLE.
REQ-016 In RD_REQ, chipselect=1, read=1 and address=source pointer SHALL hold until the cycle in which waitrequest=0, after which the state SHALL go to RD_WAIT.
REQ-017 RD_WAIT SHALL last READ_LATENCY−1 further cycles; readdata SHALL be captured in the cycle READ_LATENCY cycles after read was accepted, after which the state SHALL go to WR_REQ.
REQ-018 In WR_REQ, chipselect=1, write=1, address=destination pointer and writedata=captured word SHALL hold stable until waitrequest=0.
REQ-019 On write acceptance, both pointers SHALL increment by 1 modulo 2^ADDR_W (silent wrap) and the remaining count SHALL decrement; the state SHALL then go to RD_REQ if the count is still non-zero, otherwise to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-021 byteenable SHALL be 4'hF at all times; read and write SHALL never be asserted together; chipselect=read|write.
REQ-022 With waitrequest=0 and READ_LATENCY=1, each word SHALL take 3 cycles, and busy SHALL be high for 3·len+1 cycles starting the cycle after start.
REQ-023 The copy SHALL run forward only; overlapping regions SHALL give forward-copy semantics.

Reset
REQ-024 While reset=1, the block SHALL hold state IDLE, and busy, done, chipselect, read, write, address and writedata SHALL all be 0.
REQ-025 A reset during a copy SHALL abort it in the next cycle, with no done pulse and no further bus requests.

Configuration
REQ-026 With macro MEM_BLOCK_COPIER_CHECKSUM_EN defined, the block SHALL add output checksum (32 bits), cleared on an accepted start and on reset, and updated as checksum += captured word (mod 2^32) on each write acceptance.
REQ-027 With MEM_BLOCK_COPIER_CHECKSUM_EN defined, checksum SHALL be stable from DONE until the next accepted start.
REQ-028 Without MEM_BLOCK_COPIER_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-029 Package mem_block_copier_pkg SHALL hold the state enum, the BYTEENABLE_ALL constant and the READ_LATENCY legal-range constants.
REQ-030 One sub-module, mem_block_copier_rdlat, SHALL implement the READ_LATENCY-deep capture-strobe shift register.

Verification
REQ-031 Scenario 1: src=0x010, dst=0x200, len=4, waitrequest=0, source holds 0x11111111..0x44444444 -> the same four words appear at 0x200..0x203, busy is high for 13 cycles, and done pulses once on the 13th.
REQ-032 Scenario 2: len=0 -> exactly one busy=1/done=1 cycle and no read or write asserted.
REQ-033 Scenario 3: waitrequest randomly high 50% of the time, len=8 -> requests held stable while stalled, and all 8 words are copied correctly.
REQ-034 Scenario 4: src=0x3FE, dst=0x000, len=4 -> reads from 0x3FE, 0x3FF, 0x000, 0x001 (wrap), and writes to 0x000..0x003.
REQ-035 Scenario 5: reset asserted during the 3rd word of len=6 -> next cycle IDLE, all outputs 0, no done, and a subsequent start works normally.
REQ-036 Scenario 6: with MEM_BLOCK_COPIER_CHECKSUM_EN defined, copy words 0xFFFFFFFF and 0x00000002 -> checksum = 0x00000001.
